// File: rtl/pacman_pkg.sv
// Shared types for the Pac-Man motion block: directions, FSM states, tile size.
package pacman_pkg;

  // log2 of the tile edge in pixels (8x8 tiles)
  localparam int TILE_SHIFT_DEF = 3;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    LEFT  = 2'd1,
    DOWN  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    IDLE,
    CHK_REQ,
    WAIT_REQ,
    CHK_CUR,
    WAIT_CUR,
    STEP
  } state_t;

  // Reverse of a direction; a reversal never needs a wall query.
  function automatic dir_t opposite(input dir_t d);
    case (d)
      UP:      return DOWN;
      DOWN:    return UP;
      LEFT:    return RIGHT;
      default: return LEFT;
    endcase
  endfunction

endpackage

// File: rtl/pacman_next_tile.sv
// Neighbour-tile calculator: the tile one step away from (tile_x, tile_y) in dir.
// Optional feature macro: PACMAN_TUNNEL_EN wraps columns -1 and MAZE_W around the
// maze; without it those columns are reported as out of range.
module pacman_next_tile
  import pacman_pkg::*;
#(
  parameter int MAZE_W = 28,
  parameter int MAZE_H = 31
) (
  input  logic [4:0] tile_x,
  input  logic [4:0] tile_y,
  input  dir_t       dir,
  output logic [4:0] nx,
  output logic [4:0] ny,
  output logic       out_of_range
);

  localparam logic signed [5:0] W_S = 6'(MAZE_W);
  localparam logic signed [5:0] H_S = 6'(MAZE_H);

  logic signed [5:0] sx;
  logic signed [5:0] sy;

  // Signed 6-bit step so that -1 and MAZE_W/MAZE_H are representable before the range test.
  always_comb begin
    sx = signed'({1'b0, tile_x});
    sy = signed'({1'b0, tile_y});
    out_of_range = 1'b0;
    case (dir)
      UP:      sy = sy - 6'sd1;
      DOWN:    sy = sy + 6'sd1;
      LEFT:    sx = sx - 6'sd1;
      default: sx = sx + 6'sd1;
    endcase
    if (sy < 6'sd0 || sy >= H_S) begin
      out_of_range = 1'b1;
    end
`ifdef PACMAN_TUNNEL_EN
    if (sx < 6'sd0) begin
      sx = W_S - 6'sd1;
    end else if (sx >= W_S) begin
      sx = 6'sd0;
    end
`else
    if (sx < 6'sd0 || sx >= W_S) begin
      out_of_range = 1'b1;
    end
`endif
    nx = sx[4:0];
    ny = sy[4:0];
  end

endmodule

// File: rtl/pacman_motion.sv
// Pac-Man motion controller: one pixel per frame_tick, turns only on tile-aligned
// positions after a wall query, stops in front of walls.
// Optional feature macro: PACMAN_TUNNEL_EN lets the sprite wrap through the side
// tunnel; without it the position never leaves the maze.
module pacman_motion
  import pacman_pkg::*;
#(
  parameter logic [9:0] ORIGIN_X   = 10'd0,
  parameter logic [9:0] ORIGIN_Y   = 10'd0,
  parameter logic [9:0] START_X    = 10'd120,
  parameter logic [9:0] START_Y    = 10'd228,
  parameter int         TILE_SHIFT = TILE_SHIFT_DEF,
  parameter int         MAZE_W     = 28,
  parameter int         MAZE_H     = 31
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       dir_valid,
  input  logic [1:0] dir_req,
  output logic       wall_req,
  output logic [4:0] tile_x,
  output logic [4:0] tile_y,
  input  logic       wall_ack,
  input  logic       wall_hit,
  output logic [9:0] pacman_xloc,
  output logic [9:0] pacman_yloc,
  output logic [1:0] facing,
  output logic       moving,
  output logic       frame_overrun
);

`ifdef PACMAN_TUNNEL_EN
  // Rightmost maze-relative x; crossing it wraps to the other side.
  localparam logic [9:0] MX_MAX = 10'((MAZE_W << TILE_SHIFT) - 1);
`endif

  state_t     state_reg, state_next;
  logic [9:0] xloc_reg, xloc_next;
  logic [9:0] yloc_reg, yloc_next;
  dir_t       facing_reg, facing_next;
  logic       moving_reg, moving_next;
  logic       wall_req_reg, wall_req_next;
  logic [4:0] tile_x_reg, tile_x_next;
  logic [4:0] tile_y_reg, tile_y_next;
  logic       overrun_reg, overrun_next;
  logic       pend_valid_reg, pend_valid_next;
  dir_t       pend_dir_reg, pend_dir_next;
  logic       pend_clear;

  logic [9:0] mx, my;
  logic [4:0] cur_tx, cur_ty;
  logic       aligned;
  logic       ack;
  dir_t       query_dir;
  logic [4:0] nt_x, nt_y;
  logic       nt_oor;

  assign mx      = xloc_reg - ORIGIN_X;
  assign my      = yloc_reg - ORIGIN_Y;
  assign cur_tx  = 5'(mx >> TILE_SHIFT);
  assign cur_ty  = 5'(my >> TILE_SHIFT);
  assign aligned = (mx[TILE_SHIFT-1:0] == '0) && (my[TILE_SHIFT-1:0] == '0);
  assign ack     = wall_ack && wall_req_reg;
  // CHK_REQ probes the requested direction, every other state the current one.
  assign query_dir = (state_reg == CHK_REQ) ? pend_dir_reg : facing_reg;

  pacman_next_tile #(
    .MAZE_W(MAZE_W),
    .MAZE_H(MAZE_H)
  ) u_next_tile (
    .tile_x      (cur_tx),
    .tile_y      (cur_ty),
    .dir         (query_dir),
    .nx          (nt_x),
    .ny          (nt_y),
    .out_of_range(nt_oor)
  );

  // Next-state and datapath updates for the per-frame move sequence.
  always_comb begin
    state_next    = state_reg;
    xloc_next     = xloc_reg;
    yloc_next     = yloc_reg;
    facing_next   = facing_reg;
    moving_next   = moving_reg;
    wall_req_next = wall_req_reg;
    tile_x_next   = tile_x_reg;
    tile_y_next   = tile_y_reg;
    overrun_next  = frame_tick && (state_reg != IDLE);
    pend_clear    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (frame_tick) state_next = CHK_REQ;
      end
      CHK_REQ: begin
        if (pend_valid_reg && pend_dir_reg == opposite(facing_reg)) begin
          facing_next = pend_dir_reg;
          pend_clear  = 1'b1;
          state_next  = STEP;
        end else if (aligned && pend_valid_reg && pend_dir_reg != facing_reg) begin
          if (nt_oor) begin
            // Off-maze tile behaves as a wall: keep the request, try straight ahead.
            state_next = CHK_CUR;
          end else begin
            wall_req_next = 1'b1;
            tile_x_next   = nt_x;
            tile_y_next   = nt_y;
            state_next    = WAIT_REQ;
          end
        end else begin
          state_next = CHK_CUR;
        end
      end
      WAIT_REQ: begin
        if (ack) begin
          wall_req_next = 1'b0;
          if (!wall_hit) begin
            facing_next = pend_dir_reg;
            pend_clear  = 1'b1;
            state_next  = STEP;
          end else begin
            state_next = CHK_CUR;
          end
        end
      end
      CHK_CUR: begin
        if (!aligned) begin
          state_next = STEP;
        end else if (nt_oor) begin
          moving_next = 1'b0;
          state_next  = IDLE;
        end else begin
          wall_req_next = 1'b1;
          tile_x_next   = nt_x;
          tile_y_next   = nt_y;
          state_next    = WAIT_CUR;
        end
      end
      WAIT_CUR: begin
        if (ack) begin
          wall_req_next = 1'b0;
          if (wall_hit) begin
            moving_next = 1'b0;
            state_next  = IDLE;
          end else begin
            state_next = STEP;
          end
        end
      end
      STEP: begin
        moving_next = 1'b1;
        state_next  = IDLE;
        case (facing_reg)
          UP:   yloc_next = yloc_reg - 10'd1;
          DOWN: yloc_next = yloc_reg + 10'd1;
          LEFT: begin
`ifdef PACMAN_TUNNEL_EN
            if (mx == 10'd0) xloc_next = ORIGIN_X + MX_MAX;
            else
`endif
            xloc_next = xloc_reg - 10'd1;
          end
          default: begin
`ifdef PACMAN_TUNNEL_EN
            if (mx == MX_MAX) xloc_next = ORIGIN_X;
            else
`endif
            xloc_next = xloc_reg + 10'd1;
          end
        endcase
      end
      default: state_next = IDLE;
    endcase
  end

  // Pending request: a fresh dir_valid always wins over clearing on apply.
  always_comb begin
    pend_valid_next = pend_valid_reg;
    pend_dir_next   = pend_dir_reg;
    if (dir_valid) begin
      pend_valid_next = 1'b1;
      pend_dir_next   = dir_t'(dir_req);
    end else if (pend_clear) begin
      pend_valid_next = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      xloc_reg       <= START_X;
      yloc_reg       <= START_Y;
      facing_reg     <= LEFT;
      moving_reg     <= 1'b0;
      wall_req_reg   <= 1'b0;
      tile_x_reg     <= 5'd0;
      tile_y_reg     <= 5'd0;
      overrun_reg    <= 1'b0;
      pend_valid_reg <= 1'b0;
      pend_dir_reg   <= UP;
    end else begin
      state_reg      <= state_next;
      xloc_reg       <= xloc_next;
      yloc_reg       <= yloc_next;
      facing_reg     <= facing_next;
      moving_reg     <= moving_next;
      wall_req_reg   <= wall_req_next;
      tile_x_reg     <= tile_x_next;
      tile_y_reg     <= tile_y_next;
      overrun_reg    <= overrun_next;
      pend_valid_reg <= pend_valid_next;
      pend_dir_reg   <= pend_dir_next;
    end
  end

  assign wall_req      = wall_req_reg;
  assign tile_x        = tile_x_reg;
  assign tile_y        = tile_y_reg;
  assign pacman_xloc   = xloc_reg;
  assign pacman_yloc   = yloc_reg;
  assign facing        = facing_reg;
  assign moving        = moving_reg;
  assign frame_overrun = overrun_reg;

endmodule

// File: tb/tb_pacman_motion.sv
// Directed bench for pacman_motion: scoreboard of expected queries and positions.
// ORIGIN_Y is offset by 4 so the start position sits on a tile corner.
module tb_pacman_motion;
  import pacman_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       dir_valid = 1'b0;
  logic [1:0] dir_req = 2'd0;
  logic       wall_req;
  logic [4:0] tile_x, tile_y;
  logic       wall_ack = 1'b0;
  logic       wall_hit = 1'b0;
  logic [9:0] pacman_xloc, pacman_yloc;
  logic [1:0] facing;
  logic       moving;
  logic       frame_overrun;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [4:0] tx;
    logic [4:0] ty;
    logic       hit;
  } query_t;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic [1:0] f;
    logic       m;
  } exp_t;

  query_t qq[$];
  exp_t   sq[$];

  pacman_motion #(
    .ORIGIN_X(10'd0),
    .ORIGIN_Y(10'd4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .frame_tick   (frame_tick),
    .dir_valid    (dir_valid),
    .dir_req      (dir_req),
    .wall_req     (wall_req),
    .tile_x       (tile_x),
    .tile_y       (tile_y),
    .wall_ack     (wall_ack),
    .wall_hit     (wall_hit),
    .pacman_xloc  (pacman_xloc),
    .pacman_yloc  (pacman_yloc),
    .facing       (facing),
    .moving       (moving),
    .frame_overrun(frame_overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dir(input dir_t d);
    dir_valid = 1'b1;
    dir_req   = d;
    cyc();
    dir_valid = 1'b0;
    $display("dir_valid dir=%0d", d);
  endtask

  // One frame: push expected queries/result, tick, answer queries, compare result.
  task automatic step(input int nq, input int tx0, input int ty0, input logic h0,
                      input int tx1, input int ty1, input logic h1,
                      input int ex, input int ey, input dir_t ef, input logic em);
    query_t q;
    exp_t   e;
    int     budget;
    logic   seen;
    if (nq > 0) begin q.tx = 5'(tx0); q.ty = 5'(ty0); q.hit = h0; qq.push_back(q); end
    if (nq > 1) begin q.tx = 5'(tx1); q.ty = 5'(ty1); q.hit = h1; qq.push_back(q); end
    e.x = 10'(ex); e.y = 10'(ey); e.f = ef; e.m = em;
    sq.push_back(e);
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    for (int k = 0; k < nq; k++) begin
      budget = 0;
      while (wall_req !== 1'b1 && budget < 20) begin
        cyc();
        budget++;
      end
      q = qq.pop_front();
      check("query_seen", 32'(wall_req), 1);
      if (wall_req === 1'b1) begin
        check("query_tile_x", 32'(tile_x), 32'(q.tx));
        check("query_tile_y", 32'(tile_y), 32'(q.ty));
        wall_hit = q.hit;
        wall_ack = 1'b1;
        cyc();
        wall_ack = 1'b0;
        wall_hit = 1'b0;
      end
    end
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      if (wall_req === 1'b1) seen = 1'b1;
    end
    check("no_extra_query", 32'(seen), 0);
    e = sq.pop_front();
    check("xloc", 32'(pacman_xloc), 32'(e.x));
    check("yloc", 32'(pacman_yloc), 32'(e.y));
    check("facing", 32'(facing), 32'(e.f));
    check("moving", 32'(moving), 32'(e.m));
    $display("tick nq=%0d x=%0d y=%0d facing=%0d moving=%0d", nq, pacman_xloc, pacman_yloc,
             facing, moving);
  endtask

  initial begin
    int budget;
    query_t q;
    // Reset state
    repeat (3) cyc();
    rst = 1'b0;
    check("rst_xloc", 32'(pacman_xloc), 120);
    check("rst_yloc", 32'(pacman_yloc), 228);
    check("rst_facing", 32'(facing), 32'(LEFT));
    check("rst_moving", 32'(moving), 0);
    check("rst_wall_req", 32'(wall_req), 0);
    check("rst_tile", 32'({tile_x, tile_y}), 0);
    check("rst_overrun", 32'(frame_overrun), 0);
    $display("reset x=%0d y=%0d", pacman_xloc, pacman_yloc);

    // Straight run left, 120 -> 115; only the aligned start queries
    step(1, 14, 28, 1'b0, 0, 0, 1'b0, 119, 228, LEFT, 1'b1);
    for (int x = 119; x >= 116; x--) step(0, 0, 0, 1'b0, 0, 0, 1'b0, x - 1, 228, LEFT, 1'b1);

    // Reversal mid-tile: no query, immediate step
    set_dir(RIGHT);
    step(0, 0, 0, 1'b0, 0, 0, 1'b0, 116, 228, RIGHT, 1'b1);
    set_dir(LEFT);
    step(0, 0, 0, 1'b0, 0, 0, 1'b0, 115, 228, LEFT, 1'b1);

    // UP requested at mx%8=3: deferred until x=112, then turn
    set_dir(UP);
    for (int x = 115; x >= 113; x--) step(0, 0, 0, 1'b0, 0, 0, 1'b0, x - 1, 228, LEFT, 1'b1);
    step(1, 14, 27, 1'b0, 0, 0, 1'b0, 112, 227, UP, 1'b1);

    // Turn back LEFT at the next aligned row
    set_dir(LEFT);
    for (int y = 227; y >= 221; y--) step(0, 0, 0, 1'b0, 0, 0, 1'b0, 112, y - 1, UP, 1'b1);
    step(1, 13, 27, 1'b0, 0, 0, 1'b0, 111, 220, LEFT, 1'b1);
    for (int x = 111; x >= 105; x--) step(0, 0, 0, 1'b0, 0, 0, 1'b0, x - 1, 220, LEFT, 1'b1);

    // Blocked both ways: stop; then UP blocked, LEFT open; UP applied at next open tile
    set_dir(UP);
    step(2, 13, 26, 1'b1, 12, 27, 1'b1, 104, 220, LEFT, 1'b0);
    step(2, 13, 26, 1'b1, 12, 27, 1'b0, 103, 220, LEFT, 1'b1);
    for (int x = 103; x >= 97; x--) step(0, 0, 0, 1'b0, 0, 0, 1'b0, x - 1, 220, LEFT, 1'b1);
    step(1, 12, 26, 1'b0, 0, 0, 1'b0, 96, 219, UP, 1'b1);
    for (int y = 219; y >= 213; y--) step(0, 0, 0, 1'b0, 0, 0, 1'b0, 96, y - 1, UP, 1'b1);

    // Stalled query: overrun pulses, position frozen, reset drops wall_req
    q.tx = 5'd12; q.ty = 5'd25; q.hit = 1'b0;
    qq.push_back(q);
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    budget = 0;
    while (wall_req !== 1'b1 && budget < 20) begin
      cyc();
      budget++;
    end
    q = qq.pop_front();
    check("stall_query_seen", 32'(wall_req), 1);
    check("stall_tile", 32'({tile_x, tile_y}), 32'({q.tx, q.ty}));
    for (int n = 0; n < 3; n++) begin
      repeat (4) cyc();
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      check("overrun_pulse", 32'(frame_overrun), 1);
      cyc();
      check("overrun_clear", 32'(frame_overrun), 0);
      check("stall_xloc", 32'(pacman_xloc), 96);
      check("stall_yloc", 32'(pacman_yloc), 212);
      check("stall_wall_req", 32'(wall_req), 1);
      $display("dropped tick %0d overrun seen x=%0d y=%0d", n, pacman_xloc, pacman_yloc);
    end
    rst = 1'b1;
    cyc();
    check("rst_mid_wall_req", 32'(wall_req), 0);
    rst = 1'b0;
    wall_ack = 1'b1;
    cyc();
    wall_ack = 1'b0;
    repeat (3) cyc();
    check("late_ack_wall_req", 32'(wall_req), 0);
    check("late_ack_xloc", 32'(pacman_xloc), 120);
    check("late_ack_yloc", 32'(pacman_yloc), 228);
    check("late_ack_facing", 32'(facing), 32'(LEFT));
    $display("reset during wait x=%0d y=%0d wall_req=%0d", pacman_xloc, pacman_yloc, wall_req);

    // Walk to the left maze edge
    for (int x = 120; x >= 1; x--)
      step((x % 8 == 0) ? 1 : 0, x / 8 - 1, 28, 1'b0, 0, 0, 1'b0, x - 1, 228, LEFT, 1'b1);
`ifdef PACMAN_TUNNEL_EN
    step(1, 27, 28, 1'b0, 0, 0, 1'b0, 223, 228, LEFT, 1'b1);
    step(0, 0, 0, 1'b0, 0, 0, 1'b0, 222, 228, LEFT, 1'b1);
`else
    step(0, 0, 0, 1'b0, 0, 0, 1'b0, 0, 228, LEFT, 1'b0);
    step(0, 0, 0, 1'b0, 0, 0, 1'b0, 0, 228, LEFT, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
